// File: rtl/reg_file_alu_pipe.sv
// Register file with an 8-operation ALU and one execute->writeback pipeline stage.
// The result and the Z/N/C/V flags are registered. The writeback value is bypassed
// to the operand reads. Register 0 always reads as zero.
module reg_file_alu_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic              write_enable,
  input  logic              ALUSrc,
  input  logic [2:0]        ALUControl,
  input  logic [DATA_W-1:0] immediate,
  output logic [DATA_W-1:0] ALUResult,
  output logic              result_valid,
  output logic              Zero,
  output logic              Negative,
  output logic              Carry,
  output logic              Ovf,
  output logic [DATA_W-1:0] cpu_out
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam int unsigned SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] wa_q;
  logic              we_q;

  logic [DATA_W-1:0] rd1, rd2, srcb, result;
  logic [DATA_W:0]   sum_ext;
  logic              carry_c, ovf_c;
  op_e               op;

  assign op      = op_e'(ALUControl);
  assign cpu_out = regs[NREGS-1];

  // Operand read: zero register, then writeback bypass, then array.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (RA1 != '0) rd1 = (we_q && (wa_q == RA1)) ? ALUResult : regs[RA1];
    if (RA2 != '0) rd2 = (we_q && (wa_q == RA2)) ? ALUResult : regs[RA2];
    srcb = ALUSrc ? immediate : rd2;
  end

  // ALU datapath and flag generation.
  always_comb begin
    result  = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    sum_ext = '0;
    unique case (op)
      OP_AND: result = rd1 & srcb;
      OP_OR:  result = rd1 | srcb;
      OP_ADD: begin
        sum_ext = {1'b0, rd1} + {1'b0, srcb};
        result  = sum_ext[DATA_W-1:0];
        carry_c = sum_ext[DATA_W];
        ovf_c   = (rd1[DATA_W-1] == srcb[DATA_W-1]) &&
                  (result[DATA_W-1] != rd1[DATA_W-1]);
      end
      OP_SUB: begin
        result  = rd1 - srcb;
        carry_c = (rd1 >= srcb);
        ovf_c   = (rd1[DATA_W-1] != srcb[DATA_W-1]) &&
                  (result[DATA_W-1] != rd1[DATA_W-1]);
      end
      OP_XOR: result = rd1 ^ srcb;
      OP_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(rd1) < $signed(srcb))};
      OP_SHL: result = rd1 << srcb[SH_W-1:0];
      OP_SHR: result = rd1 >> srcb[SH_W-1:0];
      default: result = '0;
    endcase
  end

  // Execute->writeback pipeline register; result and flags hold while idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALUResult    <= '0;
      Zero         <= 1'b0;
      Negative     <= 1'b0;
      Carry        <= 1'b0;
      Ovf          <= 1'b0;
      result_valid <= 1'b0;
      wa_q         <= '0;
      we_q         <= 1'b0;
    end else if (in_valid) begin
      ALUResult    <= result;
      Zero         <= (result == '0);
      Negative     <= result[DATA_W-1];
      Carry        <= carry_c;
      Ovf          <= ovf_c;
      result_valid <= 1'b1;
      wa_q         <= WA;
      we_q         <= write_enable && (WA != '0);
    end else begin
      result_valid <= 1'b0;
      we_q         <= 1'b0;
    end
  end

  // Register array writeback from the pipeline register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we_q) begin
      regs[wa_q] <= ALUResult;
    end
  end

endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// Directed and random checks of reg_file_alu_pipe against a behavioural model with a
// scoreboard of expected results.
module tb_reg_file_alu_pipe;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] RA1 = '0, RA2 = '0, WA = '0;
  logic       write_enable = 1'b0, ALUSrc = 1'b0;
  logic [2:0] ALUControl = '0;
  logic [7:0] immediate = '0;
  logic [7:0] ALUResult, cpu_out;
  logic       result_valid, Zero, Negative, Carry, Ovf;

  reg_file_alu_pipe #(.DATA_W(8), .ADDR_W(4)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .RA1(RA1), .RA2(RA2), .WA(WA),
    .write_enable(write_enable), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .immediate(immediate), .ALUResult(ALUResult), .result_valid(result_valid),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Ovf(Ovf), .cpu_out(cpu_out)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] res;
    logic z, n, c, v;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  logic [7:0] mregs [16];
  logic [7:0] m_res;
  logic [3:0] m_wa;
  logic       m_we, m_rv, m_z, m_n, m_c, m_v;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t alu_ref(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op);
    exp_t e;
    logic [8:0] w;
    e = '0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        w = {1'b0, a} + {1'b0, b};
        e.res = w[7:0];
        e.c = w[8];
        e.v = (a[7] == b[7]) && (e.res[7] != a[7]);
      end
      3'd3: begin
        e.res = a - b;
        e.c = (a >= b);
        e.v = (a[7] != b[7]) && (e.res[7] != a[7]);
      end
      3'd4: e.res = a ^ b;
      3'd5: e.res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      3'd6: e.res = a << b[2:0];
      default: e.res = a >> b[2:0];
    endcase
    e.z = (e.res == 8'd0);
    e.n = e.res[7];
    return e;
  endfunction

  function automatic logic [7:0] mread(input logic [3:0] ra);
    if (ra == 4'd0) return 8'd0;
    if (m_we && m_wa == ra) return m_res;
    return mregs[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mregs[i] = 8'd0;
    m_res = '0; m_wa = '0; m_we = 0; m_rv = 0;
    m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    sb.delete();
  endtask

  // One clock: update the model at the edge, then compare 1 time unit later.
  task automatic step();
    exp_t e;
    @(posedge CLK);
    if (m_we) mregs[m_wa] = m_res;
    if (in_valid) begin
      m_res = pend.res; m_z = pend.z; m_n = pend.n; m_c = pend.c; m_v = pend.v;
      m_wa = WA; m_we = write_enable && (WA != 4'd0); m_rv = 1;
    end else begin
      m_rv = 0; m_we = 0;
    end
    #1;
    chk("result_valid", result_valid, m_rv);
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("sb_res", ALUResult, e.res);
        chk("sb_flags", {Zero, Negative, Carry, Ovf}, {e.z, e.n, e.c, e.v});
      end
    end
    chk("hold_res", ALUResult, m_res);
    chk("cpu_out", cpu_out, mregs[15]);
  endtask

  task automatic issue(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa,
                       input logic we, input logic src, input logic [2:0] op,
                       input logic [7:0] imm);
    logic [7:0] a, b;
    in_valid = 1; RA1 = ra1; RA2 = ra2; WA = wa; write_enable = we;
    ALUSrc = src; ALUControl = op; immediate = imm;
    a = mread(ra1);
    b = src ? imm : mread(ra2);
    pend = alu_ref(a, b, op);
    sb.push_back(pend);
    step();
  endtask

  task automatic idle();
    in_valid = 0; write_enable = 0;
    step();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    #2 RST = 1;
    in_valid = 0; write_enable = 0;
    #1;
    chk("rst_res", ALUResult, 8'd0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_flags", {Zero, Negative, Carry, Ovf}, 4'b0);
    chk("rst_cpu", cpu_out, 8'd0);
    model_clear();
    #2 RST = 0;
  endtask

  initial begin
    model_clear();
    RST = 1;
    #12;
    pulse_reset();

    // 1: read after reset
    issue(4'd5, 4'd9, 4'd0, 0, 0, 3'd2, 8'h00);
    chk("t1_res", ALUResult, 8'h00);
    chk("t1_zero", Zero, 1'b1);
    chk("t1_valid", result_valid, 1'b1);
    chk("t1_cpu", cpu_out, 8'h00);

    // 2: back-to-back dependent ops through the bypass
    issue(4'd0, 4'd0, 4'd1, 1, 1, 3'd2, 8'h7F);
    chk("t2_r1", ALUResult, 8'h7F);
    issue(4'd1, 4'd0, 4'd2, 1, 1, 3'd2, 8'h01);
    chk("t2_res", ALUResult, 8'h80);
    chk("t2_nvc", {Negative, Ovf, Carry}, 3'b110);

    // 3: SUB / SLT / SHL on r3=5
    issue(4'd0, 4'd0, 4'd3, 1, 1, 3'd2, 8'h05);
    issue(4'd3, 4'd0, 4'd0, 0, 1, 3'd3, 8'h06);
    chk("t3_sub", ALUResult, 8'hFF);
    chk("t3_sub_cn", {Carry, Negative}, 2'b01);
    issue(4'd3, 4'd0, 4'd0, 0, 1, 3'd5, 8'h06);
    chk("t3_slt", ALUResult, 8'h01);
    issue(4'd3, 4'd0, 4'd0, 0, 1, 3'd6, 8'h0A);
    chk("t3_shl", ALUResult, 8'h14);
    issue(4'd3, 4'd3, 4'd0, 0, 0, 3'd2, 8'h00);
    chk("t3_both", ALUResult, 8'h0A);

    // 4: register 0 is never written; r15 drives cpu_out one cycle later
    issue(4'd0, 4'd0, 4'd0, 1, 1, 3'd2, 8'hAB);
    chk("t4_wa0_valid", result_valid, 1'b1);
    issue(4'd0, 4'd0, 4'd0, 0, 0, 3'd1, 8'h00);
    chk("t4_r0", ALUResult, 8'h00);
    issue(4'd0, 4'd0, 4'd15, 1, 1, 3'd2, 8'h3C);
    chk("t4_cpu_early", cpu_out, 8'h00);
    idle();
    chk("t4_cpu", cpu_out, 8'h3C);

    // 5: idle holds the result, pending write completes; reset discards it
    issue(4'd0, 4'd0, 4'd4, 1, 1, 3'd2, 8'h5A);
    idle();
    chk("t5_valid_drop", result_valid, 1'b0);
    chk("t5_hold", ALUResult, 8'h5A);
    issue(4'd4, 4'd0, 4'd0, 0, 1, 3'd2, 8'h00);
    chk("t5_r4", ALUResult, 8'h5A);
    issue(4'd0, 4'd0, 4'd4, 1, 1, 3'd2, 8'h77);
    pulse_reset();
    issue(4'd4, 4'd15, 4'd0, 0, 0, 3'd1, 8'h00);
    chk("t5_r4_lost", ALUResult, 8'h00);
    chk("t5_cpu", cpu_out, 8'h00);

    // 6: random traffic, then read back the whole array
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 70)
        issue(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), 8'($urandom));
      else
        idle();
    end
    for (int r = 1; r < 16; r++) begin
      issue(4'(r), 4'd0, 4'd0, 0, 1, 3'd1, 8'h00);
      chk("sweep", ALUResult, mregs[r]);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
